score_tally: RTL and testbench

SCORE_TALLY -- requirements
Module: score_tally

---
 rtl/score_tally_if.sv | 28 ++
 rtl/score_tally.sv | 180 ++++++++++++++++++
 tb/tb_score_tally.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_tally_if.sv
`default_nettype none
// ============================================================================
//  Module      : score_tally_if
//  Description : Event, button and display bundle for the score tally block.
//                The master side is the game logic / panel; the slave side
//                is the tally itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface score_tally_if;
    logic        xWin;
    logic        oWin;
    logic        draw;
    logic        modeBtn;
    logic        clearBtn;
    logic [15:0] displayNumber;
    logic [1:0]  mode;

    modport master (
        output xWin, oWin, draw, modeBtn, clearBtn,
        input  displayNumber, mode
    );

    modport slave (
        input  xWin, oWin, draw, modeBtn, clearBtn,
        output displayNumber, mode
    );
endinterface
`default_nettype wire

// File: rtl/score_tally.sv
`default_nettype none
// ============================================================================
//  Module      : score_tally
//  Description : Counts X wins, O wins, draws and games played from one-cycle
//                game-result pulses. Two debounced push-buttons step the
//                display mode and clear all counters. The selected value is
//                presented as a registered 0..9999 number for a 4-digit
//                decimal display.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_tally #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_WINS        = 99,
    parameter int MAX_TOTAL       = 9999
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    score_tally_if.slave bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int                c_cnt_w     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [6:0]        c_max_wins  = 7'(MAX_WINS);
    localparam logic [13:0]       c_max_total = 14'(MAX_TOTAL);
    localparam logic [15:0]       c_disp_max  = 16'd9999;

    // Button index: 0 = mode, 1 = clear
    localparam int                c_btn_mode  = 0;
    localparam int                c_btn_clear = 1;

    typedef enum logic [1:0] {
        ST_SCORE = 2'd0,
        ST_DRAWS = 2'd1,
        ST_GAMES = 2'd2,
        ST_RSVD  = 2'd3
    } mode_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [1:0]  w_btn_raw;
    logic [1:0]  w_press;
    logic [2:0]  w_evt;
    logic        w_single;
    logic [15:0] w_score;
    logic [15:0] w_disp_sel;
    logic [15:0] w_disp_next;

    logic [6:0]  r_xwins;
    logic [6:0]  r_owins;
    logic [13:0] r_draws;
    logic [13:0] r_games;
    mode_t       r_mode;
    logic [15:0] r_display;

    assign w_btn_raw = {bus.clearBtn, bus.modeBtn};

    // ------------------------------------------------------------------
    // Per-button synchroniser, debounce and press detector. The press
    // pulse is registered on the same edge the accepted level rises, so
    // it is exactly one cycle wide and a held button gives one press.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic [1:0]         r_sync;
        logic               r_acc;
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_press;

        // Two-flop synchroniser, stability counter and accepted level
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync  <= 2'b00;
                r_acc   <= 1'b0;
                r_cnt   <= '0;
                r_press <= 1'b0;
            end else begin
                r_sync  <= {r_sync[0], w_btn_raw[gi]};
                r_press <= 1'b0;
                if (r_sync[1] != r_acc) begin
                    if (r_cnt == c_cnt_last) begin
                        r_acc   <= r_sync[1];
                        r_cnt   <= '0;
                        r_press <= r_sync[1];
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end else begin
                    // Synchronised level matches again: any bounce restarts
                    r_cnt <= '0;
                end
            end
        end

        assign w_press[gi] = r_press;
    end

    // ------------------------------------------------------------------
    // Event qualification: exactly one of the three pulses may be high
    // ------------------------------------------------------------------
    assign w_evt    = {bus.xWin, bus.oWin, bus.draw};
    assign w_single = (w_evt == 3'b100) || (w_evt == 3'b010) || (w_evt == 3'b001);

    // Saturating counters; a clear press overrides any same-cycle event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xwins <= '0;
            r_owins <= '0;
            r_draws <= '0;
            r_games <= '0;
        end else if (w_press[c_btn_clear]) begin
            r_xwins <= '0;
            r_owins <= '0;
            r_draws <= '0;
            r_games <= '0;
        end else if (w_single) begin
            if (bus.xWin && (r_xwins < c_max_wins)) begin
                r_xwins <= r_xwins + 7'd1;
            end
            if (bus.oWin && (r_owins < c_max_wins)) begin
                r_owins <= r_owins + 7'd1;
            end
            if (bus.draw && (r_draws < c_max_total)) begin
                r_draws <= r_draws + 14'd1;
            end
            // Games keep counting even when the player/draw count is pinned
            if (r_games < c_max_total) begin
                r_games <= r_games + 14'd1;
            end
        end
    end

    // Display mode FSM: SCORE -> DRAWS -> GAMES -> SCORE on each press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= ST_SCORE;
        end else if (w_press[c_btn_mode]) begin
            case (r_mode)
                ST_SCORE: r_mode <= ST_DRAWS;
                ST_DRAWS: r_mode <= ST_GAMES;
                default:  r_mode <= ST_SCORE;
            endcase
        end else if (r_mode == ST_RSVD) begin
            r_mode <= ST_SCORE;
        end
    end

    // ------------------------------------------------------------------
    // Display value selection, clamped to the 4-digit range
    // ------------------------------------------------------------------
    assign w_score = (16'(r_xwins) * 16'd100) + 16'(r_owins);

    // Pick the counter view for the current mode and clamp it
    always_comb begin
        w_disp_sel = w_score;
        case (r_mode)
            ST_SCORE: w_disp_sel = w_score;
            ST_DRAWS: w_disp_sel = 16'(r_draws);
            default:  w_disp_sel = 16'(r_games);
        endcase
        w_disp_next = (w_disp_sel > c_disp_max) ? c_disp_max : w_disp_sel;
    end

    // Display register: one cycle behind the counter and mode registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_display <= '0;
        end else begin
            r_display <= w_disp_next;
        end
    end

    assign bus.displayNumber = r_display;
    assign bus.mode          = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_score_tally.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_tally
//  Description : Self-checking bench for score_tally: vector table, directed
//                multi-cycle sequences and a randomized run against a
//                behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_tally;

    localparam int D  = 4;
    localparam int MW = 99;
    localparam int MT = 9999;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    score_tally_if bus();

    score_tally #(
        .DEBOUNCE_CYCLES(D),
        .MAX_WINS(MW),
        .MAX_TOTAL(MT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model. Buttons: raw samples are kept in a history; a
    // level is accepted when the D synchronised samples preceding an edge
    // all disagree with the current accepted level.
    // ------------------------------------------------------------------
    int     m_x, m_o, m_d, m_g, m_mode, m_disp;
    bit     m_pm, m_pc;
    bit     acc_m, acc_c;
    bit [D:0] hm, hc;

    task automatic deb(input bit [D:0] h, input bit acc_in,
                       output bit acc_out, output bit press);
        acc_out = acc_in;
        press   = 1'b0;
        if (!acc_in && (h[D:1] == {D{1'b1}})) begin
            acc_out = 1'b1;
            press   = 1'b1;
        end else if (acc_in && (h[D:1] == {D{1'b0}})) begin
            acc_out = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_x = 0; m_o = 0; m_d = 0; m_g = 0; m_mode = 0; m_disp = 0;
            m_pm = 0; m_pc = 0; acc_m = 0; acc_c = 0; hm = '0; hc = '0;
        end else begin
            int  nd, hot;
            bit  na, np;
            case (m_mode)
                0:       nd = m_x * 100 + m_o;
                1:       nd = m_d;
                default: nd = m_g;
            endcase
            m_disp = (nd > 9999) ? 9999 : nd;
            hot = int'(bus.xWin) + int'(bus.oWin) + int'(bus.draw);
            if (m_pc) begin
                m_x = 0; m_o = 0; m_d = 0; m_g = 0;
            end else if (hot == 1) begin
                if (bus.xWin) m_x = (m_x < MW) ? m_x + 1 : m_x;
                if (bus.oWin) m_o = (m_o < MW) ? m_o + 1 : m_o;
                if (bus.draw) m_d = (m_d < MT) ? m_d + 1 : m_d;
                m_g = (m_g < MT) ? m_g + 1 : m_g;
            end
            if (m_pm) m_mode = (m_mode + 1) % 3;
            deb(hm, acc_m, na, np); acc_m = na; m_pm = np;
            deb(hc, acc_c, na, np); acc_c = na; m_pc = np;
            hm = {hm[D-1:0], bus.modeBtn};
            hc = {hc[D-1:0], bus.clearBtn};
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model during the random phase
    always @(negedge clk) begin
        if (chk_en) begin
            check("rnd_disp", int'(bus.displayNumber), m_disp);
            check("rnd_mode", int'(bus.mode), m_mode);
        end
    end

    task automatic pulse(input bit x, input bit o, input bit d);
        bus.xWin = x; bus.oWin = o; bus.draw = d;
        @(negedge clk);
        bus.xWin = 0; bus.oWin = 0; bus.draw = 0;
    endtask

    task automatic press_btn(input int which, input int hold);
        if (which == 0) bus.modeBtn = 1'b1; else bus.clearBtn = 1'b1;
        repeat (hold) @(negedge clk);
        bus.modeBtn = 1'b0; bus.clearBtn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        bit x;
        bit o;
        bit d;
        int exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int prev;
        int rem_m, rem_c;

        tbl[0] = '{1, 0, 0, 100};
        tbl[1] = '{1, 0, 0, 200};
        tbl[2] = '{1, 0, 0, 300};
        tbl[3] = '{0, 1, 0, 301};
        tbl[4] = '{0, 1, 0, 302};
        tbl[5] = '{1, 1, 0, 302};
        tbl[6] = '{0, 0, 1, 302};
        tbl[7] = '{1, 0, 1, 302};
        tbl[8] = '{1, 1, 1, 302};
        tbl[9] = '{0, 1, 0, 303};

        bus.xWin = 0; bus.oWin = 0; bus.draw = 0;
        bus.modeBtn = 0; bus.clearBtn = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_disp", int'(bus.displayNumber), 0);
        check("rst_mode", int'(bus.mode), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Vector table in SCORE mode, with latency checks
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            pulse(tbl[i].x, tbl[i].o, tbl[i].d);
            check($sformatf("tbl%0d_lat", i), int'(bus.displayNumber), prev);
            @(negedge clk);
            check($sformatf("tbl%0d", i), int'(bus.displayNumber), tbl[i].exp);
            prev = tbl[i].exp;
        end

        // Bouncing mode button then a clean hold: one press only
        bus.modeBtn = 1; repeat (2) @(negedge clk);
        bus.modeBtn = 0; repeat (2) @(negedge clk);
        bus.modeBtn = 1; repeat (10) @(negedge clk);
        bus.modeBtn = 0; repeat (10) @(negedge clk);
        check("bounce_mode", int'(bus.mode), 1);
        check("bounce_draws", int'(bus.displayNumber), 1);
        press_btn(0, 10);
        check("games_mode", int'(bus.mode), 2);
        check("games_val", int'(bus.displayNumber), 7);
        press_btn(0, 10);
        check("wrap_mode", int'(bus.mode), 0);
        check("wrap_score", int'(bus.displayNumber), 303);

        // Clear, then saturate xWins
        press_btn(1, 10);
        check("clr_score", int'(bus.displayNumber), 0);
        for (int i = 0; i < 105; i++) begin
            pulse(1, 0, 0);
            @(negedge clk);
        end
        @(negedge clk);
        check("sat_score", int'(bus.displayNumber), 9900);
        press_btn(0, 10);
        check("sat_draws", int'(bus.displayNumber), 0);
        press_btn(0, 10);
        check("sat_games", int'(bus.displayNumber), 105);
        press_btn(0, 10);
        press_btn(0, 10);
        check("draws_mode", int'(bus.mode), 1);

        // Clear press coinciding with a draw pulse
        pulse(0, 0, 1);
        pulse(0, 0, 1);
        @(negedge clk);
        check("pre_clr_draws", int'(bus.displayNumber), 2);
        bus.clearBtn = 1;
        repeat (6) @(negedge clk);
        pulse(0, 0, 1);
        bus.clearBtn = 0;
        repeat (10) @(negedge clk);
        check("clrdraw_disp", int'(bus.displayNumber), 0);
        check("clrdraw_mode", int'(bus.mode), 1);
        press_btn(0, 10);
        check("clrdraw_games", int'(bus.displayNumber), 0);
        pulse(1, 0, 0);
        @(negedge clk);
        check("games_one", int'(bus.displayNumber), 1);

        // Asynchronous reset mid-debounce
        bus.modeBtn = 1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_disp", int'(bus.displayNumber), 0);
        check("async_mode", int'(bus.mode), 0);
        bus.modeBtn = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("async_nopress", int'(bus.mode), 0);

        // Button held across reset release gives exactly one press
        rst_n = 1'b0;
        bus.modeBtn = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("held_early", int'(bus.mode), 0);
        repeat (12) @(negedge clk);
        check("held_press", int'(bus.mode), 1);
        bus.modeBtn = 0;
        repeat (10) @(negedge clk);
        check("held_single", int'(bus.mode), 1);

        // Randomized run against the model
        chk_en = 1'b1;
        rem_m = 5;
        rem_c = 300;
        for (int c = 0; c < 4000; c++) begin
            bus.xWin = ($urandom_range(0, 3) == 0);
            bus.oWin = ($urandom_range(0, 3) == 0);
            bus.draw = ($urandom_range(0, 5) == 0);
            if (rem_m == 0) begin
                bus.modeBtn = ~bus.modeBtn;
                rem_m = $urandom_range(1, 12);
            end else begin
                rem_m--;
            end
            if (rem_c == 0) begin
                bus.clearBtn = ~bus.clearBtn;
                rem_c = bus.clearBtn ? $urandom_range(1, 8) : $urandom_range(150, 900);
            end else begin
                rem_c--;
            end
            @(negedge clk);
        end
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
